// File: rtl/game_pkg.sv
// Shared game definitions for the key/lamp progress logic.
// Holds the top-level game-state encodings, the item-box corners
// (half-resolution pixel coordinates, inclusive, before pickup margin)
// and the progress FSM state type.
package game_pkg;

  typedef logic [3:0] game_state_t;

  localparam game_state_t ST_TITLE    = 4'd0;
  localparam game_state_t ST_STAFF    = 4'd1;
  localparam game_state_t ST_STAGE1   = 4'd2;
  localparam game_state_t ST_SUCCESS1 = 4'd3;
  localparam game_state_t ST_STAGE2   = 4'd4;
  localparam game_state_t ST_SUCCESS2 = 4'd5;
  localparam game_state_t ST_STAGE3   = 4'd6;
  localparam game_state_t ST_SUCCESS3 = 4'd7;
  localparam game_state_t ST_FAIL     = 4'd8;

  typedef struct packed {
    logic [9:0] x_lo;
    logic [9:0] x_hi;
    logic [9:0] y_lo;
    logic [9:0] y_hi;
  } box_t;

  localparam box_t KEY0_BOX = '{x_lo: 10'd70,  x_hi: 10'd79,  y_lo: 10'd40,  y_hi: 10'd49};
  localparam box_t KEY1_BOX = '{x_lo: 10'd250, x_hi: 10'd259, y_lo: 10'd40,  y_hi: 10'd49};
  localparam box_t KEY2_BOX = '{x_lo: 10'd215, x_hi: 10'd224, y_lo: 10'd220, y_hi: 10'd229};
  localparam box_t LAMP_BOX = '{x_lo: 10'd70,  x_hi: 10'd79,  y_lo: 10'd220, y_hi: 10'd229};

  typedef enum logic [1:0] {
    FSM_IDLE = 2'd0,
    FSM_PLAY = 2'd1,
    FSM_DONE = 2'd2
  } fsm_t;

  function automatic logic is_stage(input game_state_t s);
    return (s == ST_STAGE1) || (s == ST_STAGE2) || (s == ST_STAGE3);
  endfunction

endpackage

// File: rtl/box_hit.sv
// Combinational inclusive hit-test of a player position against a box
// grown by M pixels on every side.
// Ports:
//   px, py               player position (half-res, 9 bits)
//   x_lo/x_hi/y_lo/y_hi  box corners, inclusive (10 bits)
//   hit                  1 when the position lies inside the grown box
module box_hit #(
  parameter int M = 4
) (
  input  logic [8:0] px,
  input  logic [8:0] py,
  input  logic [9:0] x_lo,
  input  logic [9:0] x_hi,
  input  logic [9:0] y_lo,
  input  logic [9:0] y_hi,
  output logic       hit
);

  localparam logic [9:0] MW = 10'(M);

  logic [9:0] px_w, py_w;
  logic [9:0] xl, xh, yl, yh;

  // Low bounds clamp at 0 so boxes near the screen edge cannot underflow.
  always_comb begin
    px_w = {1'b0, px};
    py_w = {1'b0, py};
    xl   = (x_lo >= MW) ? (x_lo - MW) : 10'd0;
    yl   = (y_lo >= MW) ? (y_lo - MW) : 10'd0;
    xh   = x_hi + MW;
    yh   = y_hi + MW;
    hit  = (px_w >= xl) && (px_w <= xh) && (py_w >= yl) && (py_w <= yh);
  end

endmodule

// File: rtl/key_progress.sv
// Key collection and lamp-timer logic for the current game stage.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   state               top-level game state
//   player_x, player_y  player position (half-res)
//   tick                one pulse per video frame
//   pick                debounced action-button pulse
//   key_find            keys collected in this stage (0..3)
//   isDark              1 = room dark (STAGE2 only)
//   stage_clear         one-cycle pulse when the third key is taken
module key_progress
  import game_pkg::*;
#(
  parameter int GRAB_MARGIN  = 4,
  parameter int LIGHT_FRAMES = 600,
  parameter int TW           = 10
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] state,
  input  logic [8:0] player_x,
  input  logic [8:0] player_y,
  input  logic       tick,
  input  logic       pick,
  output logic [1:0] key_find,
  output logic       isDark,
  output logic       stage_clear
);

  localparam logic [TW-1:0] LIGHT_LOAD = TW'(LIGHT_FRAMES);

  fsm_t          fsm_q, fsm_d;
  game_state_t   prev_state;
  logic [TW-1:0] timer_q, timer_d;
  logic [1:0]    key_find_d;
  logic          is_dark_d, stage_clear_d;

  box_t key_box;
  logic key_hit, lamp_hit;
  logic in_stage, entry, in_stage2, key_take, lamp_pick;

  always_comb begin
    case (key_find)
      2'd0:    key_box = KEY0_BOX;
      2'd1:    key_box = KEY1_BOX;
      default: key_box = KEY2_BOX;
    endcase
  end

  box_hit #(.M(GRAB_MARGIN)) u_key_hit (
    .px(player_x), .py(player_y),
    .x_lo(key_box.x_lo), .x_hi(key_box.x_hi),
    .y_lo(key_box.y_lo), .y_hi(key_box.y_hi),
    .hit(key_hit)
  );

  box_hit #(.M(GRAB_MARGIN)) u_lamp_hit (
    .px(player_x), .py(player_y),
    .x_lo(LAMP_BOX.x_lo), .x_hi(LAMP_BOX.x_hi),
    .y_lo(LAMP_BOX.y_lo), .y_hi(LAMP_BOX.y_hi),
    .hit(lamp_hit)
  );

  always_comb begin
    in_stage  = is_stage(state);
    entry     = in_stage && (state != prev_state);
    in_stage2 = (state == ST_STAGE2);
    // KEY0 in STAGE2 can only be found with the lamp lit.
    key_take  = (fsm_q == FSM_PLAY) && in_stage && pick && key_hit &&
                !(in_stage2 && (key_find == 2'd0) && isDark);
    // A pick that also takes a key never touches the lamp.
    lamp_pick = (fsm_q == FSM_PLAY) && in_stage2 && pick && lamp_hit && !key_take;
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q      <= FSM_IDLE;
      prev_state <= ST_TITLE;
    end else begin
      fsm_q      <= fsm_d;
      prev_state <= state;
    end
  end

  // FSM next-state
  always_comb begin
    fsm_d = fsm_q;
    if (entry)
      fsm_d = FSM_PLAY;
    else if (!in_stage)
      fsm_d = FSM_IDLE;
    else if (key_take && (key_find == 2'd2))
      fsm_d = FSM_DONE;
  end

  // Output / datapath next values
  always_comb begin
    key_find_d    = key_find;
    is_dark_d     = isDark;
    timer_d       = timer_q;
    stage_clear_d = 1'b0;
    if (entry) begin
      key_find_d = 2'd0;
      timer_d    = '0;
      is_dark_d  = in_stage2;
    end else if (in_stage && (fsm_q == FSM_PLAY)) begin
      if (key_take) begin
        key_find_d = key_find + 2'd1;
        if (key_find == 2'd2)
          stage_clear_d = 1'b1;
      end
      if (in_stage2) begin
        if (lamp_pick) begin
          is_dark_d = 1'b0;
          timer_d   = LIGHT_LOAD;
        end else if (tick && !isDark && (timer_q != '0)) begin
          timer_d = timer_q - TW'(1);
          if (timer_q == TW'(1))
            is_dark_d = 1'b1;
        end
      end
    end
  end

  // Registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_find    <= 2'd0;
      isDark      <= 1'b0;
      stage_clear <= 1'b0;
      timer_q     <= '0;
    end else begin
      key_find    <= key_find_d;
      isDark      <= is_dark_d;
      stage_clear <= stage_clear_d;
      timer_q     <= timer_d;
    end
  end

endmodule

// File: tb/tb_key_progress.sv
module tb_key_progress;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] state;
  logic [8:0] player_x, player_y;
  logic       tick, pick;
  logic [1:0] key_find;
  logic       isDark, stage_clear;

  int checks = 0;
  int failures = 0;

  key_progress #(.GRAB_MARGIN(4), .LIGHT_FRAMES(3), .TW(10)) dut (
    .clk(clk), .rst_n(rst_n), .state(state),
    .player_x(player_x), .player_y(player_y),
    .tick(tick), .pick(pick),
    .key_find(key_find), .isDark(isDark), .stage_clear(stage_clear)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One clock edge, then settle just past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Single-cycle pick at (x,y) with the given tick value.
  task automatic do_pick(input int x, input int y, input logic t);
    player_x = 9'(x);
    player_y = 9'(y);
    pick = 1'b1;
    tick = t;
    step();
    pick = 1'b0;
    tick = 1'b0;
  endtask

  task automatic do_tick();
    tick = 1'b1;
    step();
    tick = 1'b0;
  endtask

  task automatic set_state(input logic [3:0] s);
    state = s;
    step();
  endtask

  initial begin
    rst_n = 1'b0; state = 4'd0; player_x = '0; player_y = '0;
    tick = 1'b0; pick = 1'b0;
    step(); step();
    check("rst_key_find", key_find, 0);
    check("rst_isDark", isDark, 0);
    check("rst_stage_clear", stage_clear, 0);
    rst_n = 1'b1;
    step();

    // STAGE1: collect all three keys
    set_state(4'd2);
    check("s1_entry_kf", key_find, 0);
    do_pick(75, 45, 1'b0);
    check("s1_key0", key_find, 1);
    check("s1_light", isDark, 0);
    check("s1_no_clear", stage_clear, 0);
    do_pick(255, 45, 1'b0);
    check("s1_key1", key_find, 2);
    do_pick(220, 225, 1'b0);
    check("s1_key2", key_find, 3);
    check("s1_clear_hi", stage_clear, 1);
    step();
    check("s1_clear_lo", stage_clear, 0);
    do_pick(220, 225, 1'b0);
    check("done_hold", key_find, 3);
    check("done_no_clear", stage_clear, 0);

    // Hit boundaries on KEY0 (x range 66..83, y range 36..53)
    set_state(4'd6);
    check("s3_entry_kf", key_find, 0);
    do_pick(65, 40, 1'b0);
    check("edge_65_40_miss", key_find, 0);
    do_pick(66, 40, 1'b0);
    check("edge_66_40_hit", key_find, 1);
    set_state(4'd2);
    check("reentry_kf", key_find, 0);
    do_pick(84, 53, 1'b0);
    check("edge_84_53_miss", key_find, 0);
    do_pick(83, 53, 1'b0);
    check("edge_83_53_hit", key_find, 1);
    do_pick(75, 225, 1'b0);
    check("s1_lamp_ignored", isDark, 0);

    // Stage change mid-play re-initialises
    do_pick(255, 45, 1'b0);
    check("mid_kf2", key_find, 2);
    set_state(4'd6);
    check("switch_s3_kf", key_find, 0);
    do_pick(75, 45, 1'b0);
    check("s3_key0", key_find, 1);
    set_state(4'd8);
    check("fail_hold", key_find, 1);
    do_pick(255, 45, 1'b0);
    check("fail_pick_ignored", key_find, 1);

    // STAGE2: darkness gates KEY0, lamp lights room
    set_state(4'd4);
    check("s2_entry_dark", isDark, 1);
    check("s2_entry_kf", key_find, 0);
    do_pick(75, 45, 1'b0);
    check("s2_dark_key0", key_find, 0);
    do_pick(75, 225, 1'b0);
    check("s2_lamp_on", isDark, 0);
    do_pick(75, 45, 1'b0);
    check("s2_lit_key0", key_find, 1);
    do_tick();
    check("tick1_lit", isDark, 0);
    do_tick();
    check("tick2_lit", isDark, 0);
    do_tick();
    check("tick3_dark", isDark, 1);

    // Reload coincident with tick: full timer, then three ticks to dark
    do_pick(75, 225, 1'b1);
    check("reload_lit", isDark, 0);
    do_tick();
    do_tick();
    check("reload_2ticks_lit", isDark, 0);
    do_tick();
    check("reload_3ticks_dark", isDark, 1);

    // Only KEY0 needs light
    do_pick(255, 45, 1'b0);
    check("s2_dark_key1", key_find, 2);

    // Asynchronous reset mid-cycle
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("async_kf", key_find, 0);
    check("async_dark", isDark, 0);
    check("async_clear", stage_clear, 0);
    step();
    rst_n = 1'b1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/key_progress.md
Name: key_progress

Overview:
- Sequential game-logic stage that produces the `key_find[1:0]` and `isDark` signals consumed by the key/light object renderer.
- Tracks which of the three keys the player has collected in the current stage.
- In STAGE2, runs the lamp timer that decides whether the room is dark.
- Emits a one-cycle `stage_clear` pulse to the top-level state machine when the third key is taken.

Parameters:
- GRAB_MARGIN, 4: pixels (half-res units) added on every side of a 10x10 item box for pickup hit-test.
- LIGHT_FRAMES, 600: frame ticks the lamp stays lit after being switched on.
- TW, 10: width of the lamp timer; must satisfy LIGHT_FRAMES < 2^TW.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- state  input  4  top-level game state (TITLE=0, STAFF=1, STAGE1=2, SUCCESS1=3, STAGE2=4, SUCCESS2=5, STAGE3=6, SUCCESS3=7, FAIL=8)
- player_x  input  9  player position, half-res x (0..319)
- player_y  input  9  player position, half-res y (0..239)
- tick  input  1  one-cycle pulse per video frame
- pick  input  1  one-cycle debounced action-button pulse
- key_find  output  2  keys collected so far in this stage (0..3)
- isDark  output  1  room lighting, 1 = dark (meaningful in STAGE2 only)
- stage_clear  output  1  one-cycle pulse when the third key is collected

Behaviour:
- Reset (rst_n=0, asynchronous): FSM=IDLE, key_find=0, isDark=0, stage_clear=0, timer=0, prev_state=TITLE. All outputs are registered.
- Item boxes, inclusive, before margin:
  - KEY0: x 70..79, y 40..49
  - KEY1: x 250..259, y 40..49
  - KEY2: x 215..224, y 220..229
  - LAMP: x 70..79, y 220..229
- Hit rule: x_lo-M <= player_x <= x_hi+M, and likewise for y, with M=GRAB_MARGIN. Compute in 10-bit unsigned and clamp the low bound at 0 so there is no underflow.
- FSM states: IDLE, PLAY, DONE.
  - Stage entry: `state` is STAGE1, STAGE2 or STAGE3 and differs from the registered `prev_state`.
    - Next edge: PLAY, key_find=0, stage_clear=0, timer=0.
    - isDark=1 if the new state is STAGE2, else 0.
    - This applies from any FSM state, so a stage change mid-play fully re-initialises.
  - Non-stage state: FSM→IDLE next edge. key_find and isDark hold their values; pick and tick are ignored.
  - PLAY, key pickup: `pick`=1 and the player hits box KEY[key_find] → key_find increments next edge.
    - In STAGE2, the KEY0 pickup additionally requires isDark=0.
    - When key_find goes 2→3: stage_clear=1 for exactly one cycle, FSM→DONE.
  - DONE: key_find holds at 3; pick and tick are ignored; stays until stage entry or a non-stage state.
- Lamp, PLAY in STAGE2 only:
  - `pick` with a LAMP hit → isDark=0 and timer loads LIGHT_FRAMES on the next edge. Re-picking while lit reloads the timer.
  - Otherwise, tick while isDark=0 and timer>0 → timer decrements.
  - Tick when timer==1 → timer=0 and isDark=1 on the same edge.
  - In STAGE1/STAGE3, isDark is held at 0 and the timer is frozen.
- Priority:
  - If one `pick` hits both the current key box and LAMP (possible only with a large GRAB_MARGIN), only the key is taken.
  - If pick-at-lamp and tick land in the same cycle, the reload wins and the tick is dropped.
- Pickup latency: 1 cycle from `pick` to the key_find update. pick with no hit has no effect.
- key_find never exceeds 3 and never wraps.

Decomposition:
- Shared package `game_pkg`:
  - state encodings TITLE..FAIL
  - item-box corner constants KEY0..KEY2 and LAMP (x_lo, x_hi, y_lo, y_hi)
  - FSM enum
- One natural sub-module, `box_hit`: combinational inclusive hit-test of (px, py) against parameterised box corners plus margin. It is instantiated twice: once for the current key (muxed by key_find) and once for the lamp.

Test Plan:
- Reset, then state=STAGE1, player (75,45), pick → key_find 0→1 one cycle after pick; isDark=0; stage_clear=0.
- STAGE1, pick in sequence at (255,45) then (220,225) → key_find reaches 3, stage_clear high exactly one cycle, FSM DONE; a further pick leaves key_find=3.
- STAGE2 entry → isDark=1. Pick at (75,45) → key_find stays 0. Pick at (75,225) → isDark=0. Pick at (75,45) → key_find=1.
- STAGE2 with LIGHT_FRAMES=3: lamp on, then 3 ticks → isDark returns to 1 on the edge of the third tick. Lamp pick coincident with a tick → timer=3, not 2.
- Hit boundaries with M=4: player (66,40) hits KEY0, (65,40) misses, (83,53) hits, (84,53) misses.
- Mid-operation changes:
  - STAGE1 with key_find=2, state switched to STAGE3 → key_find=0 next edge.
  - state=FAIL → key_find holds, pick ignored.
  - rst_n pulsed low mid-cycle → outputs clear immediately, without waiting for a clock edge.
